// File: rtl/vram_fetch.sv
// -----------------------------------------------------------------------------
// vram_fetch
//
// Burst reader that pulls a run of consecutive 32-bit words out of VRAM
// through the arbiter's read port and queues them in a small
// first-word-fall-through FIFO for a downstream consumer.
//
// A burst is armed in IDLE by a one-cycle start pulse that latches the base
// address and the word count (0 encodes 256). While FETCH is active the block
// keeps at most one read request outstanding. It re-presents a request the
// arbiter did not grant, and it stops issuing when the FIFO could overflow.
//
// Ports
//   clk         single clock, all state on the rising edge
//   rst         synchronous, active-high reset
//   start       one-cycle burst request (ignored while a burst is running)
//   base_addr   first VRAM word address, sampled with start
//   word_count  number of words, sampled with start; 0 means 256
//   busy        burst in progress (state == FETCH)
//   done        one-cycle pulse in the cycle after the last grant
//   bus_addr    word address of the current read request
//   bus_strobe  read request to the arbiter
//   bus_ack     registered grant, high the cycle after a granted request
//   bus_rddata  read data, valid in the bus_ack cycle
//   rd_data     FIFO head word (valid while rd_valid)
//   rd_valid    FIFO not empty
//   rd_en       consumer pop, ignored while rd_valid is low
// -----------------------------------------------------------------------------
module vram_fetch #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [14:0] base_addr,
  input  logic [7:0]  word_count,
  output logic        busy,
  output logic        done,
  output logic [14:0] bus_addr,
  output logic        bus_strobe,
  input  logic        bus_ack,
  input  logic [31:0] bus_rddata,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_en
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FILL_W = CNT_W + 1;
  // Highest FIFO occupancy (after this cycle's push) at which another
  // request may still be issued. The request in flight then fills the last slot.
  localparam logic [FILL_W-1:0] FILL_LIMIT = FILL_W'(FIFO_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [14:0]         req_addr_r;
  logic [8:0]          issue_left_r;
  logic [8:0]          recv_left_r;
  logic                done_r;
  logic [31:0]         mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    fifo_count_r;

  logic                accept_ack_s;
  logic                last_ack_s;
  logic                push_s;
  logic                pop_s;
  logic                issue_pending_s;
  logic                fifo_room_s;
  logic [FILL_W-1:0]   fill_s;
  logic [8:0]          burst_len_s;

  // 15-bit word-address increment; wraps 0x7FFF -> 0x0000.
  function automatic logic [14:0] addr_inc(input logic [14:0] a);
    return a + 15'd1;
  endfunction

  // Grant qualification, FIFO handshakes and issue throttling.
  always_comb begin
    accept_ack_s    = 1'b0;
    last_ack_s      = 1'b0;
    push_s          = 1'b0;
    pop_s           = 1'b0;
    issue_pending_s = 1'b0;
    fifo_room_s     = 1'b0;
    fill_s          = {FILL_W{1'b0}};
    burst_len_s     = 9'd0;

    // Grants outside FETCH (e.g. the one trailing a reset) are dropped.
    accept_ack_s = (state_r == ST_FETCH) && bus_ack;
    last_ack_s   = accept_ack_s && (recv_left_r == 9'd1);
    push_s       = accept_ack_s;
    pop_s        = rd_en && (fifo_count_r != {CNT_W{1'b0}});

    // The grant arriving this cycle retires one pending word before the
    // next request is considered, which lets requests go out back to back.
    issue_pending_s = (issue_left_r > {8'd0, accept_ack_s});
    fill_s          = {1'b0, fifo_count_r} + {{CNT_W{1'b0}}, accept_ack_s};
    fifo_room_s     = (fill_s <= FILL_LIMIT);

    if (word_count == 8'd0) begin
      burst_len_s = 9'd256;
    end else begin
      burst_len_s = {1'b0, word_count};
    end
  end

  // Next-state logic for the IDLE/FETCH controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (last_ack_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Burst address, outstanding-word counters and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr_r   <= 15'd0;
      issue_left_r <= 9'd0;
      recv_left_r  <= 9'd0;
      done_r       <= 1'b0;
    end else begin
      done_r <= last_ack_s;
      if ((state_r == ST_IDLE) && start) begin
        req_addr_r   <= base_addr;
        issue_left_r <= burst_len_s;
        recv_left_r  <= burst_len_s;
      end else if (accept_ack_s) begin
        req_addr_r   <= addr_inc(req_addr_r);
        issue_left_r <= issue_left_r - 9'd1;
        recv_left_r  <= recv_left_r - 9'd1;
      end
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      fifo_count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1);
        2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // FIFO storage. Contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= bus_rddata;
    end
  end

  // Output drive. bus_addr looks one word ahead in a grant cycle so that the
  // next request follows without a bubble.
  always_comb begin
    busy       = (state_r == ST_FETCH);
    done       = done_r;
    bus_strobe = (state_r == ST_FETCH) && issue_pending_s && fifo_room_s;
    rd_data    = mem_r[rd_ptr_r];
    rd_valid   = (fifo_count_r != {CNT_W{1'b0}});
    if (bus_ack) begin
      bus_addr = addr_inc(req_addr_r);
    end else begin
      bus_addr = req_addr_r;
    end
  end

endmodule

// File: tb/tb_vram_fetch.sv
// -----------------------------------------------------------------------------
// tb_vram_fetch
//
// Self-checking bench for vram_fetch. A behavioural model tracks:
//   - the burst as "active / words still to receive / next expected address"
//   - the FIFO as a queue of expected words
// An arbiter model answers every strobe one cycle later. The returned data
// is a fixed function of the presented address, so address errors also
// show up as data errors. Every cycle is compared against the model.
// -----------------------------------------------------------------------------
module tb_vram_fetch;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] base_addr;
  logic [7:0]  word_count;
  logic        busy;
  logic        done;
  logic [14:0] bus_addr;
  logic        bus_strobe;
  logic        bus_ack;
  logic [31:0] bus_rddata;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_en;

  always #5 clk = ~clk;

  vram_fetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .bus_addr   (bus_addr),
    .bus_strobe (bus_strobe),
    .bus_ack    (bus_ack),
    .bus_rddata (bus_rddata),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_en      (rd_en)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // behavioural model
  bit          m_active    = 1'b0;
  int          m_recv_left = 0;
  logic [14:0] m_next_addr = 15'd0;
  logic [31:0] m_q[$];
  bit          m_done_due  = 1'b0;

  // arbiter model
  bit          ack_next  = 1'b0;
  logic [14:0] ack_addr  = 15'd0;
  int          ack_mode  = 0;
  int          hold_left = 0;
  logic [14:0] hold_addr = 15'd0;

  // statistics
  int          n_grants   = 0;
  int          n_done     = 0;
  int          max_occ    = 0;
  int          watch_cnt  = 0;
  logic [14:0] watch_addr = 15'h7FFF;
  logic [14:0] last_grant = 15'd0;
  int          last_done_cyc = 0;
  bit          step_done = 1'b0;

  typedef struct {
    logic [14:0] base;
    logic [7:0]  cnt;
    int          exp_words;
    logic [14:0] exp_last;
    int          exp_lat;
  } vec_t;

  vec_t vt[5];

  function automatic logic [31:0] word_of(input logic [14:0] a);
    return {~a[7:0], 2'b10, a, a[6:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive the arbiter, compare, advance the model.
  task automatic step();
    int pre_size;
    bit ack_taken;
    bit do_pop;
    bit exp_strobe;
    bus_ack    = ack_next;
    bus_rddata = ack_next ? word_of(ack_addr) : $urandom();
    #1;
    pre_size  = m_q.size();
    step_done = (done === 1'b1);
    if (step_done) begin
      n_done++;
      last_done_cyc = cyc;
    end
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done_due));
      chk("rd_valid", 32'(rd_valid), 32'(pre_size != 0));
      if (pre_size != 0) chk("rd_data", rd_data, m_q[0]);
    end
    ack_taken = 1'b0;
    if (bus_ack && m_active) begin
      m_q.push_back(word_of(m_next_addr));
      n_grants++;
      last_grant  = m_next_addr;
      m_next_addr = m_next_addr + 15'd1;
      m_recv_left--;
      ack_taken = 1'b1;
      if (m_q.size() > max_occ) max_occ = m_q.size();
    end
    exp_strobe = m_active && (m_recv_left > 0) && (m_q.size() <= DEPTH - 1);
    if (chk_en) begin
      chk("bus_strobe", 32'(bus_strobe), 32'(exp_strobe));
      if (exp_strobe) chk("bus_addr", 32'(bus_addr), 32'(m_next_addr));
    end
    if (bus_strobe === 1'b1 && bus_addr == watch_addr) watch_cnt++;
    do_pop = rd_en && (pre_size != 0);
    // arbiter: decide the grant for the request presented this cycle
    if (bus_strobe === 1'b1) begin
      ack_addr = bus_addr;
      if (hold_left > 0 && bus_addr == hold_addr) begin
        ack_next = 1'b0;
        hold_left--;
      end else if (ack_mode == 0) begin
        ack_next = 1'b1;
      end else begin
        ack_next = ($urandom_range(0, 99) < 60);
      end
    end else begin
      ack_next = 1'b0;
    end
    @(posedge clk);
    if (rst) begin
      m_active    = 1'b0;
      m_q.delete();
      m_done_due  = 1'b0;
      m_recv_left = 0;
      m_next_addr = 15'd0;
    end else begin
      if (do_pop) void'(m_q.pop_front());
      m_done_due = ack_taken && (m_recv_left == 0);
      if (m_active) begin
        if (m_recv_left == 0) m_active = 1'b0;
      end else if (start) begin
        m_active    = 1'b1;
        m_next_addr = base_addr;
        m_recv_left = (word_count == 8'd0) ? 256 : int'(word_count);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [14:0] b, input logic [7:0] c, output int s);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    s          = cyc;
    step();
    start      = 1'b0;
  endtask

  task automatic run_until_done(input int limit, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (step_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int s;
    logic [14:0] exp_a[5];

    vt[0] = '{15'h0100, 8'd4,  4,   15'h0103, 6};
    vt[1] = '{15'h7FFE, 8'd3,  3,   15'h0000, 5};
    vt[2] = '{15'h1234, 8'd1,  1,   15'h1234, 3};
    vt[3] = '{15'h7FF0, 8'd32, 32,  15'h000F, 34};
    vt[4] = '{15'h7F00, 8'd0,  256, 15'h7FFF, 258};

    rst = 1'b1; start = 1'b0; base_addr = 15'd0; word_count = 8'd0; rd_en = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_strobe", 32'(bus_strobe), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    step();

    // table-driven bursts: full grant rate, consumer always ready
    rd_en = 1'b1; ack_mode = 0;
    for (int v = 0; v < 5; v++) begin
      n_grants = 0; n_done = 0;
      do_start(vt[v].base, vt[v].cnt, s);
      run_until_done(400, "table");
      chk("table_words", 32'(n_grants), 32'(vt[v].exp_words));
      chk("table_last_addr", 32'(last_grant), 32'(vt[v].exp_last));
      chk("table_latency", 32'(last_done_cyc - s), 32'(vt[v].exp_lat));
      step(); step();
      chk("table_done_once", 32'(n_done), 32'd1);
    end

    // preemption: second word withheld for three cycles
    n_grants = 0; n_done = 0; watch_cnt = 0;
    watch_addr = 15'h0101; hold_addr = 15'h0101; hold_left = 3;
    do_start(15'h0100, 8'd4, s);
    run_until_done(50, "preempt");
    chk("preempt_hold_cycles", 32'(watch_cnt), 32'd4);
    chk("preempt_words", 32'(n_grants), 32'd4);
    chk("preempt_latency", 32'(last_done_cyc - s), 32'd9);
    watch_addr = 15'h7FFF;
    step(); step();

    // backpressure: 256-word burst against a stalled consumer
    rd_en = 1'b0; n_grants = 0; n_done = 0; max_occ = 0;
    do_start(15'h1000, 8'd0, s);
    for (int i = 0; i < 40; i++) step();
    chk("bp_stalled_strobe", 32'(bus_strobe), 32'd0);
    chk("bp_stalled_words", 32'(n_grants), 32'd8);
    chk("bp_stalled_busy", 32'(busy), 32'd1);
    chk("bp_stalled_valid", 32'(rd_valid), 32'd1);
    rd_en = 1'b1;
    run_until_done(700, "bp");
    chk("bp_total_words", 32'(n_grants), 32'd256);
    chk("bp_max_occupancy", 32'(max_occ), 32'd8);
    step(); step();
    chk("bp_done_once", 32'(n_done), 32'd1);

    // reset in the middle of an 8-word burst
    rd_en = 1'b0; n_grants = 0; n_done = 0;
    do_start(15'h0200, 8'd8, s);
    for (int i = 0; i < 20 && n_grants < 2; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("rst_no_done", 32'(n_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    rd_en = 1'b1; n_grants = 0; n_done = 0;
    do_start(15'h0300, 8'd1, s);
    run_until_done(20, "rst_after");
    chk("rst_after_words", 32'(n_grants), 32'd1);
    chk("rst_after_addr", 32'(last_grant), 32'h0300);
    step(); step(); step();
    chk("rst_after_empty", 32'(rd_valid), 32'd0);
    chk("rst_after_done_once", 32'(n_done), 32'd1);

    // back-to-back: second start lands in the done cycle
    rd_en = 1'b0;
    do_start(15'h0400, 8'd3, s);
    for (int i = 0; i < 50 && !m_done_due; i++) step();
    chk("b2b_reached_done", 32'(m_done_due), 32'd1);
    do_start(15'h0500, 8'd2, s);
    chk("b2b_done_with_start", 32'(step_done), 32'd1);
    run_until_done(50, "b2b");
    exp_a = '{15'h0400, 15'h0401, 15'h0402, 15'h0500, 15'h0501};
    for (int k = 0; k < 5; k++) begin
      chk("b2b_order", rd_data, word_of(exp_a[k]));
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    chk("b2b_drained", 32'(rd_valid), 32'd0);

    // randomized traffic against the model
    ack_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 399) == 0);
      start      = ($urandom_range(0, 7) == 0);
      base_addr  = 15'($urandom());
      word_count = 8'($urandom_range(0, 20));
      rd_en      = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0; start = 1'b0; rd_en = 1'b1; ack_mode = 0;
    for (int i = 0; i < 700 && (m_active || m_q.size() != 0); i++) step();
    step();
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_rd_valid", 32'(rd_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
